sound_sequencer: RTL

// - Note queue and timer sitting directly upstream of the sound block. The CPU pushes (divisor, duration) note pairs.
// - Sequencer plays them in order by driving the sound block's max_count / latch_max_count interface.
// - CPU can queue a melody and walk away instead of timing each note in software.

---
 rtl/sound_sequencer.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sound_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sound_sequencer                                            |
// | Description : Note FIFO plus duration timer feeding the sound block.     |
// |               The CPU pushes (divisor, duration) pairs. The sequencer    |
// |               plays them in order by driving max_count and pulsing       |
// |               latch_max_count, so a whole melody can be queued at once.  |
// | Option      : SOUND_SEQ_GAP_EN inserts a silent gap of GAP_TICKS ticks   |
// |               after every note so repeated notes are articulated.        |
// | Ports       : clk, rst_async_n      clock, async active-low reset        |
// |               note_divisor/duration note to enqueue (divisor 0 = rest)   |
// |               note_push, flush       1-cycle command strobes             |
// |               note_full, note_count  FIFO status                         |
// |               overflow               1-cycle pulse on rejected push      |
// |               busy                   note or gap currently timing        |
// |               max_count, latch_max_count  sound block interface          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sound_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 50000,
    parameter int DUR_W      = 12,
    parameter int GAP_TICKS  = 20
) (
    input  logic                          clk,
    input  logic                          rst_async_n,
    input  logic [25:0]                   note_divisor,
    input  logic [DUR_W-1:0]              note_duration,
    input  logic                          note_push,
    input  logic                          flush,
    output logic                          note_full,
    output logic [$clog2(FIFO_DEPTH):0]   note_count,
    output logic                          overflow,
    output logic                          busy,
    output logic [25:0]                   max_count,
    output logic                          latch_max_count
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_pw = $clog2(TICK_DIV);
    localparam int c_ew = 26 + DUR_W;

    localparam logic [c_cw-1:0] c_depth     = c_cw'(FIFO_DEPTH);
    localparam logic [c_pw-1:0] c_tick_last = c_pw'(TICK_DIV - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_play = 2'd1;
`ifdef SOUND_SEQ_GAP_EN
    localparam logic [1:0] c_st_gap  = 2'd2;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_ew-1:0]  r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             r_full;
    logic             r_overflow;
    logic [1:0]       r_state;
    logic             r_busy;
    logic [c_pw-1:0]  r_prescaler;
    logic [DUR_W-1:0] r_remaining;
    logic [25:0]      r_max_count;
    logic             r_latch;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [c_ew-1:0]  w_head;
    logic [25:0]      w_head_div;
    logic [DUR_W-1:0] w_head_dur;
    logic             w_empty;
    logic             w_push_ok;
    logic [c_cw-1:0]  w_count_nxt;
    logic             w_note_end;
    logic [1:0]       w_state_nxt;
    logic             w_pop;
    logic             w_load;
    logic             w_silence;
    logic             w_zero_rem;
    logic             w_advance;
`ifdef SOUND_SEQ_GAP_EN
    logic             w_gap_enter;
`endif

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_div = w_head[c_ew-1:DUR_W];
    assign w_head_dur = w_head[DUR_W-1:0];
    assign w_empty    = (r_count == '0);

    // A push into a full FIFO still fits if the sequencer pops the same cycle.
    assign w_push_ok  = note_push && !flush && (!r_full || w_pop);

    // remaining == 0 only occurs after a zero-duration entry was discarded
    // mid-sequence; it forces a fresh end-of-note evaluation next cycle.
    assign w_note_end = (r_remaining == '0) ||
                        ((r_prescaler == c_tick_last) && (r_remaining == DUR_W'(1)));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_silence   = 1'b0;
        w_zero_rem  = 1'b0;
        w_advance   = 1'b0;
`ifdef SOUND_SEQ_GAP_EN
        w_gap_enter = 1'b0;
`endif
        if (flush) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_dur != '0) begin
                            w_load      = 1'b1;
                            w_state_nxt = c_st_play;
                        end
                    end
                end
                c_st_play: begin
                    if (w_note_end) begin
`ifdef SOUND_SEQ_GAP_EN
                        w_gap_enter = 1'b1;
                        // A rest is already silent; avoid a redundant 0 pulse.
                        w_silence   = (r_max_count != '0);
                        w_state_nxt = c_st_gap;
`else
                        w_advance   = 1'b1;
`endif
                    end
                end
`ifdef SOUND_SEQ_GAP_EN
                c_st_gap: begin
                    if (w_note_end) begin
                        w_advance = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase

            // End of a timed interval: chain straight into the next note.
            if (w_advance) begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_dur != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = c_st_play;
                    end else begin
                        w_zero_rem  = 1'b1;
                    end
                end else begin
                    w_state_nxt = c_st_idle;
`ifndef SOUND_SEQ_GAP_EN
                    w_silence   = 1'b1;
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: validity is tracked by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {note_divisor, note_duration};
        end
    end

    // ------------------------------------------------------------------
    // State, FIFO pointers, timer and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_state     <= c_st_idle;
            r_busy      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_prescaler <= '0;
            r_remaining <= '0;
            r_max_count <= '0;
            r_latch     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != c_st_idle);
            r_overflow <= note_push && !flush && r_full && !w_pop;

            if (flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_full      <= 1'b0;
                r_prescaler <= '0;
                r_remaining <= '0;
                r_max_count <= '0;
                r_latch     <= 1'b1;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == c_depth);

                r_latch <= w_load || w_silence;
                if (w_load) begin
                    r_max_count <= w_head_div;
                end else if (w_silence) begin
                    r_max_count <= '0;
                end

                if (w_load) begin
                    r_prescaler <= '0;
                    r_remaining <= w_head_dur;
`ifdef SOUND_SEQ_GAP_EN
                end else if (w_gap_enter) begin
                    r_prescaler <= '0;
                    r_remaining <= DUR_W'(GAP_TICKS);
`endif
                end else if (w_zero_rem) begin
                    r_remaining <= '0;
                end else if (r_state != c_st_idle) begin
                    if (r_prescaler == c_tick_last) begin
                        r_prescaler <= '0;
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                    end else begin
                        r_prescaler <= r_prescaler + 1'b1;
                    end
                end
            end
        end
    end

    assign note_full       = r_full;
    assign note_count      = r_count;
    assign overflow        = r_overflow;
    assign busy            = r_busy;
    assign max_count       = r_max_count;
    assign latch_max_count = r_latch;

endmodule
`default_nettype wire
